// File: rtl/ibex_pkg.sv
// Shared types for the Ibex core slice used by the EX issue controller.
// Holds operator encodings, the multiplier configuration and the issue FSM states.
package ibex_pkg;

   typedef enum integer {
      RV32MNone        = 0,
      RV32MSlow        = 1,
      RV32MFast        = 2,
      RV32MSingleCycle = 3
   } rv32m_e;

   typedef enum logic [6:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_XOR,
      ALU_OR,
      ALU_AND,
      ALU_SRA,
      ALU_SRL,
      ALU_SLL,
      ALU_LT,
      ALU_LTU,
      ALU_GE,
      ALU_GEU,
      ALU_EQ,
      ALU_NE,
      ALU_SLT,
      ALU_SLTU
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_OP_MULL,
      MD_OP_MULH,
      MD_OP_DIV,
      MD_OP_REM
   } md_op_e;

   typedef enum logic [0:0] {
      IssIdle,
      IssExec
   } ex_issue_state_e;

   // Operator and operand fields captured on every accepted issue.
   typedef struct packed {
      alu_op_e     alu_op;
      md_op_e      md_op;
      logic [1:0]  signed_mode;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
   } issue_op_t;

   localparam int unsigned ImdValW   = 34;
   localparam int unsigned ImdValNum = 2;

endpackage

// File: rtl/ibex_wb_buffer.sv
// One-entry result register between EX and register-file write-back.
// A consume and a refill in the same cycle keep the entry valid with the new data.
module ibex_wb_buffer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic [31:0] data_i,
   input  logic        ready_i,
   output logic        space_o,
   output logic        valid_o,
   output logic [31:0] data_o
);

   logic        valid_q, valid_d;
   logic [31:0] data_q, data_d;

   assign space_o = ~valid_q | ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= 32'h0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ibex_ex_issue_ctrl.sv
// Issue-side control for the execution stage: latches one ALU/MUL/DIV op per handshake,
// sequences its multi-cycle execution, owns the intermediate values and buffers the result.
module ibex_ex_issue_ctrl import ibex_pkg::*; #(
   parameter rv32m_e RV32M    = RV32MFast,
   parameter bit     ResetAll = 1'b0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,

   input  logic                        instr_valid_i,
   output logic                        instr_ready_o,
   input  logic                        instr_is_mult_i,
   input  logic                        instr_is_div_i,
   input  alu_op_e                     alu_operator_i,
   input  md_op_e                      md_operator_i,
   input  logic [1:0]                  md_signed_mode_i,
   input  logic [31:0]                 operand_a_i,
   input  logic [31:0]                 operand_b_i,
   input  logic                        flush_i,

   output alu_op_e                     alu_operator_o,
   output md_op_e                      multdiv_operator_o,
   output logic [1:0]                  multdiv_signed_mode_o,
   output logic [31:0]                 alu_operand_a_o,
   output logic [31:0]                 alu_operand_b_o,
   output logic [31:0]                 multdiv_operand_a_o,
   output logic [31:0]                 multdiv_operand_b_o,
   output logic                        alu_instr_first_cycle_o,
   output logic                        mult_en_o,
   output logic                        div_en_o,
   output logic                        mult_sel_o,
   output logic                        div_sel_o,
   output logic                        multdiv_ready_id_o,

   input  logic [1:0]                  imd_val_we_i,
   input  logic [1:0][ImdValW-1:0]     imd_val_d_i,
   output logic [1:0][ImdValW-1:0]     imd_val_q_o,

   input  logic                        ex_valid_i,
   input  logic [31:0]                 result_ex_i,
   output logic                        wb_valid_o,
   input  logic                        wb_ready_i,
   output logic [31:0]                 wb_result_o,
   output logic                        busy_o
);

   localparam bit MdEn = (RV32M != RV32MNone);

   ex_issue_state_e          state_q, state_d;
   logic                     first_q;
   logic                     mult_q, div_q;
   issue_op_t                op_q, op_d;
   logic [1:0][ImdValW-1:0]  imd_val_q;

   logic exec;
   logic wb_space;
   logic completion;
   logic accept;

   assign exec       = (state_q == IssExec);
   assign completion = exec & ex_valid_i & wb_space & ~flush_i;
   assign accept     = instr_valid_i & instr_ready_o;

   assign op_d = '{
      alu_op:      alu_operator_i,
      md_op:       md_operator_i,
      signed_mode: md_signed_mode_i,
      operand_a:   operand_a_i,
      operand_b:   operand_b_i
   };

   ////////////////////
   // State register //
   ////////////////////

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IssIdle;
         first_q <= 1'b0;
         mult_q  <= 1'b0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= accept;
         if (accept) begin
            // Without a multiplier the op falls through to the ALU path.
            mult_q <= instr_is_mult_i & MdEn;
            div_q  <= instr_is_div_i & MdEn;
         end
      end
   end

   ////////////////
   // Next state //
   ////////////////

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IssIdle: begin
            if (accept) state_d = IssExec;
         end
         IssExec: begin
            if (completion && !accept) state_d = IssIdle;
         end
         default: state_d = IssIdle;
      endcase
      if (flush_i) state_d = IssIdle;
   end

   /////////////
   // Outputs //
   /////////////

   always_comb begin
      instr_ready_o           = ~flush_i & (~exec | completion);
      alu_instr_first_cycle_o = exec & first_q;
      mult_en_o               = exec & mult_q;
      div_en_o                = exec & div_q;
      mult_sel_o              = exec & mult_q;
      div_sel_o               = exec & div_q;
      busy_o                  = exec | wb_valid_o;
   end

   ///////////////////////
   // Operator latches  //
   ///////////////////////

   if (ResetAll) begin : g_op_reset
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            op_q <= '0;
         end else if (accept) begin
            op_q <= op_d;
         end
      end
   end else begin : g_op_noreset
      always_ff @(posedge clk_i) begin
         if (accept) begin
            op_q <= op_d;
         end
      end
   end

   assign alu_operator_o        = op_q.alu_op;
   assign multdiv_operator_o    = op_q.md_op;
   assign multdiv_signed_mode_o = op_q.signed_mode;
   assign alu_operand_a_o       = op_q.operand_a;
   assign alu_operand_b_o       = op_q.operand_b;
   assign multdiv_operand_a_o   = op_q.operand_a;
   assign multdiv_operand_b_o   = op_q.operand_b;

   ///////////////////////////
   // Intermediate values   //
   ///////////////////////////

   // Contents survive op boundaries and flushes; only reset clears them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         imd_val_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (imd_val_we_i[i] && exec) begin
               imd_val_q[i] <= imd_val_d_i[i];
            end
         end
      end
   end

   assign imd_val_q_o = imd_val_q;

   //////////////////////
   // Writeback buffer //
   //////////////////////

   ibex_wb_buffer u_wb_buffer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .load_i  (completion),
      .data_i  (result_ex_i),
      .ready_i (wb_ready_i),
      .space_o (wb_space),
      .valid_o (wb_valid_o),
      .data_o  (wb_result_o)
   );

   assign multdiv_ready_id_o = wb_space;

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Bench for ibex_ex_issue_ctrl: a rule-level model checked every cycle against a
// fast-multiplier instance and an RV32MNone instance, plus directed literal expectations.
module tb_ibex_ex_issue_ctrl;
   import ibex_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic              instr_valid, is_mult, is_div, flush, ex_valid, wb_ready;
   alu_op_e           alu_op;
   md_op_e            md_op;
   logic [1:0]        sm;
   logic [31:0]       opa, opb, result;
   logic [1:0]        imd_we;
   logic [1:0][33:0]  imd_d;

   typedef struct packed {
      logic             instr_ready;
      alu_op_e          alu_op;
      md_op_e           md_op;
      logic [1:0]       sm;
      logic [31:0]      alu_a;
      logic [31:0]      alu_b;
      logic [31:0]      md_a;
      logic [31:0]      md_b;
      logic             first;
      logic             mult_en;
      logic             div_en;
      logic             mult_sel;
      logic             div_sel;
      logic             ready_id;
      logic [1:0][33:0] imd;
      logic             wb_valid;
      logic [31:0]      wb_result;
      logic             busy;
   } out_t;

   out_t fo, no;

   ibex_ex_issue_ctrl #(.RV32M(RV32MFast), .ResetAll(1'b1)) dut_fast (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_valid_i(instr_valid), .instr_ready_o(fo.instr_ready),
      .instr_is_mult_i(is_mult), .instr_is_div_i(is_div),
      .alu_operator_i(alu_op), .md_operator_i(md_op), .md_signed_mode_i(sm),
      .operand_a_i(opa), .operand_b_i(opb), .flush_i(flush),
      .alu_operator_o(fo.alu_op), .multdiv_operator_o(fo.md_op),
      .multdiv_signed_mode_o(fo.sm),
      .alu_operand_a_o(fo.alu_a), .alu_operand_b_o(fo.alu_b),
      .multdiv_operand_a_o(fo.md_a), .multdiv_operand_b_o(fo.md_b),
      .alu_instr_first_cycle_o(fo.first),
      .mult_en_o(fo.mult_en), .div_en_o(fo.div_en),
      .mult_sel_o(fo.mult_sel), .div_sel_o(fo.div_sel),
      .multdiv_ready_id_o(fo.ready_id),
      .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(fo.imd),
      .ex_valid_i(ex_valid), .result_ex_i(result),
      .wb_valid_o(fo.wb_valid), .wb_ready_i(wb_ready), .wb_result_o(fo.wb_result),
      .busy_o(fo.busy)
   );

   ibex_ex_issue_ctrl #(.RV32M(RV32MNone), .ResetAll(1'b1)) dut_none (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_valid_i(instr_valid), .instr_ready_o(no.instr_ready),
      .instr_is_mult_i(is_mult), .instr_is_div_i(is_div),
      .alu_operator_i(alu_op), .md_operator_i(md_op), .md_signed_mode_i(sm),
      .operand_a_i(opa), .operand_b_i(opb), .flush_i(flush),
      .alu_operator_o(no.alu_op), .multdiv_operator_o(no.md_op),
      .multdiv_signed_mode_o(no.sm),
      .alu_operand_a_o(no.alu_a), .alu_operand_b_o(no.alu_b),
      .multdiv_operand_a_o(no.md_a), .multdiv_operand_b_o(no.md_b),
      .alu_instr_first_cycle_o(no.first),
      .mult_en_o(no.mult_en), .div_en_o(no.div_en),
      .mult_sel_o(no.mult_sel), .div_sel_o(no.div_sel),
      .multdiv_ready_id_o(no.ready_id),
      .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(no.imd),
      .ex_valid_i(ex_valid), .result_ex_i(result),
      .wb_valid_o(no.wb_valid), .wb_ready_i(wb_ready), .wb_result_o(no.wb_result),
      .busy_o(no.busy)
   );

   // ---------------- behavioural model ----------------
   logic             m_busy_op, m_first, m_mult, m_div, m_wb_v;
   logic [31:0]      m_wb_d, m_a, m_b;
   alu_op_e          m_alu_op;
   md_op_e           m_md_op;
   logic [1:0]       m_sm;
   logic [1:0][33:0] m_imd;

   // A result may be taken when the buffer is empty or being drained.
   function automatic logic e_rid();
      return !m_wb_v || wb_ready;
   endfunction
   function automatic logic e_done();
      return m_busy_op && ex_valid && e_rid() && !flush;
   endfunction
   function automatic logic e_rdy();
      return !flush && (!m_busy_op || e_done());
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy_op <= 1'b0; m_first <= 1'b0; m_mult <= 1'b0; m_div <= 1'b0;
         m_wb_v <= 1'b0; m_wb_d <= '0; m_a <= '0; m_b <= '0;
         m_alu_op <= ALU_ADD; m_md_op <= MD_OP_MULL; m_sm <= '0; m_imd <= '0;
      end else begin
         for (int i = 0; i < 2; i++) if (m_busy_op && imd_we[i]) m_imd[i] <= imd_d[i];
         if (flush) begin
            m_busy_op <= 1'b0; m_first <= 1'b0; m_wb_v <= 1'b0;
         end else begin
            if (e_done()) begin
               m_wb_v <= 1'b1; m_wb_d <= result;
            end else if (wb_ready) begin
               m_wb_v <= 1'b0;
            end
            if (instr_valid && e_rdy()) begin
               m_busy_op <= 1'b1; m_first <= 1'b1; m_mult <= is_mult; m_div <= is_div;
               m_alu_op <= alu_op; m_md_op <= md_op; m_sm <= sm; m_a <= opa; m_b <= opb;
            end else begin
               m_first <= 1'b0;
               if (e_done()) m_busy_op <= 1'b0;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          on_none;
      int          sel;
      logic [63:0] exp;
      string       name;
   } lit_t;
   lit_t lits[128];
   int   lit_wr = 0;
   int   lit_rd = 0;

   localparam int SWbV = 0, SWbD = 1, SImd0 = 2, SImd1 = 3, SFirst = 4, SMulEn = 5;
   localparam int SDivEn = 6, SRdy = 7, SRid = 8, SBusy = 9, SMulSel = 10, SAluA = 11;

   function automatic logic [63:0] pick(input out_t o, input int sel);
      case (sel)
         SWbV:    return 64'(o.wb_valid);
         SWbD:    return 64'(o.wb_result);
         SImd0:   return 64'(o.imd[0]);
         SImd1:   return 64'(o.imd[1]);
         SFirst:  return 64'(o.first);
         SMulEn:  return 64'(o.mult_en);
         SDivEn:  return 64'(o.div_en);
         SRdy:    return 64'(o.instr_ready);
         SRid:    return 64'(o.ready_id);
         SBusy:   return 64'(o.busy);
         SMulSel: return 64'(o.mult_sel);
         SAluA:   return 64'(o.alu_a);
         default: return 64'hdead;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_dut(input out_t o, input bit has_md, input string lbl);
      if (rst_n) begin
         chk({lbl, ".instr_ready"}, 64'(o.instr_ready), 64'(e_rdy()));
         chk({lbl, ".ready_id"}, 64'(o.ready_id), 64'(e_rid()));
      end
      chk({lbl, ".first"}, 64'(o.first), 64'(m_busy_op && m_first));
      chk({lbl, ".mult_en"}, 64'(o.mult_en), 64'(m_busy_op && m_mult && has_md));
      chk({lbl, ".div_en"}, 64'(o.div_en), 64'(m_busy_op && m_div && has_md));
      chk({lbl, ".mult_sel"}, 64'(o.mult_sel), 64'(m_busy_op && m_mult && has_md));
      chk({lbl, ".div_sel"}, 64'(o.div_sel), 64'(m_busy_op && m_div && has_md));
      chk({lbl, ".busy"}, 64'(o.busy), 64'(m_busy_op || m_wb_v));
      chk({lbl, ".wb_valid"}, 64'(o.wb_valid), 64'(m_wb_v));
      if (m_wb_v) chk({lbl, ".wb_result"}, 64'(o.wb_result), 64'(m_wb_d));
      chk({lbl, ".imd0"}, 64'(o.imd[0]), 64'(m_imd[0]));
      chk({lbl, ".imd1"}, 64'(o.imd[1]), 64'(m_imd[1]));
      chk({lbl, ".alu_op"}, 64'(o.alu_op), 64'(m_alu_op));
      chk({lbl, ".md_op"}, 64'(o.md_op), 64'(m_md_op));
      chk({lbl, ".sm"}, 64'(o.sm), 64'(m_sm));
      chk({lbl, ".alu_a"}, 64'(o.alu_a), 64'(m_a));
      chk({lbl, ".alu_b"}, 64'(o.alu_b), 64'(m_b));
      chk({lbl, ".md_a"}, 64'(o.md_a), 64'(m_a));
      chk({lbl, ".md_b"}, 64'(o.md_b), 64'(m_b));
   endtask

   always @(negedge clk) begin
      check_dut(fo, 1'b1, "fast");
      check_dut(no, 1'b0, "none");
      while (lit_rd < lit_wr) begin
         chk({"lit.", lits[lit_rd].name},
             pick(lits[lit_rd].on_none ? no : fo, lits[lit_rd].sel), lits[lit_rd].exp);
         lit_rd++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic want(input bit on_none, input int sel, input logic [63:0] exp,
                       input string name);
      lits[lit_wr] = '{on_none, sel, exp, name};
      lit_wr++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic v, input logic m, input logic d, input alu_op_e ao,
                     input md_op_e mo, input logic [31:0] a, input logic [31:0] b);
      instr_valid = v; is_mult = m; is_div = d; alu_op = ao; md_op = mo;
      sm = 2'b01; opa = a; opb = b;
   endtask

   task automatic ex(input logic v, input logic [31:0] r);
      ex_valid = v;
      result   = r;
   endtask

   initial begin
      op(1'b0, 1'b0, 1'b0, ALU_ADD, MD_OP_MULL, 32'h0, 32'h0);
      ex(1'b0, 32'h0);
      flush = 1'b0; wb_ready = 1'b1; imd_we = 2'b00; imd_d = '0;
      #1 rst_n = 1'b0;
      want(0, SWbV, 0, "rst_wb_valid"); want(0, SBusy, 0, "rst_busy");
      want(0, SImd0, 0, "rst_imd0");    want(0, SAluA, 0, "rst_alu_a");
      repeat (2) cyc();
      rst_n = 1'b1;

      // Back-to-back single-cycle ALU ops
      op(1, 0, 0, ALU_ADD, MD_OP_MULL, 32'd1, 32'd2); want(0, SRdy, 1, "b2b_rdy0"); cyc();
      op(1, 0, 0, ALU_SUB, MD_OP_MULL, 32'd10, 32'd3); ex(1, 32'd3);
      want(0, SFirst, 1, "b2b_first1"); want(0, SRdy, 1, "b2b_rdy1"); cyc();
      op(1, 0, 0, ALU_XOR, MD_OP_MULL, 32'd6, 32'd3); ex(1, 32'd7);
      want(0, SWbV, 1, "b2b_v1"); want(0, SWbD, 3, "b2b_r1");
      want(0, SFirst, 1, "b2b_first2"); want(0, SRdy, 1, "b2b_rdy2"); cyc();
      op(0, 0, 0, ALU_ADD, MD_OP_MULL, 32'd0, 32'd0); ex(1, 32'd5);
      want(0, SWbD, 7, "b2b_r2"); cyc();
      ex(0, 32'd0); want(0, SWbV, 1, "b2b_v3"); want(0, SWbD, 5, "b2b_r3"); cyc();
      want(0, SWbV, 0, "b2b_drained"); want(0, SBusy, 0, "b2b_idle"); cyc();

      // Three-cycle MUL with an intermediate-value write
      op(1, 1, 0, ALU_ADD, MD_OP_MULL, 32'd7, 32'd6); cyc();
      op(0, 0, 0, ALU_ADD, MD_OP_MULL, 32'd0, 32'd0);
      imd_we = 2'b01; imd_d[0] = 34'h1_2345_6789;
      want(0, SFirst, 1, "mul_first"); want(0, SMulEn, 1, "mul_en");
      want(0, SMulSel, 1, "mul_sel"); want(1, SMulEn, 0, "none_mul_en");
      want(1, SMulSel, 0, "none_mul_sel"); cyc();
      imd_we = 2'b00;
      want(0, SImd0, 64'h1_2345_6789, "mul_imd0"); want(0, SFirst, 0, "mul_first_c2");
      cyc();
      ex(1, 32'hDEADBEEF); cyc();

      // Writeback backpressure
      ex(0, 32'h0); wb_ready = 1'b0;
      op(1, 0, 0, ALU_ADD, MD_OP_MULL, 32'd5, 32'd0);
      want(0, SWbV, 1, "mul_v"); want(0, SWbD, 64'hDEADBEEF, "mul_res");
      want(0, SMulEn, 0, "mul_en_off"); want(1, SWbD, 64'hDEADBEEF, "none_mul_res");
      cyc();
      op(0, 0, 0, ALU_ADD, MD_OP_MULL, 32'd0, 32'd0); ex(1, 32'h1111);
      want(0, SRid, 0, "bp_rid0"); want(0, SRdy, 0, "bp_rdy0"); cyc();
      wb_ready = 1'b1;
      want(0, SRid, 1, "bp_rid1"); want(0, SWbV, 1, "bp_v_hold");
      want(0, SWbD, 64'hDEADBEEF, "bp_old"); cyc();
      ex(0, 32'h0); want(0, SWbV, 1, "bp_v_cont"); want(0, SWbD, 64'h1111, "bp_new"); cyc();
      want(0, SWbV, 0, "bp_drained"); cyc();

      // Flush in the fifth EXEC cycle of a DIV
      wb_ready = 1'b0; op(1, 0, 0, ALU_ADD, MD_OP_MULL, 32'd1, 32'd1); cyc();
      op(1, 0, 1, ALU_ADD, MD_OP_DIV, 32'd100, 32'd7); ex(1, 32'h2222); cyc();
      op(0, 0, 0, ALU_ADD, MD_OP_MULL, 32'd0, 32'd0); ex(0, 32'h0);
      want(0, SDivEn, 1, "div_en"); want(0, SWbV, 1, "div_wb_v"); cyc();
      imd_we = 2'b10; imd_d[1] = 34'h3_0000_0001; cyc();
      imd_we = 2'b00; want(0, SImd1, 64'h3_0000_0001, "div_imd1"); cyc();
      cyc();
      flush = 1'b1; op(1, 0, 0, ALU_ADD, MD_OP_MULL, 32'd9, 32'd9);
      want(0, SDivEn, 1, "fl_div_en"); want(0, SRdy, 0, "fl_rdy"); cyc();
      flush = 1'b0; op(0, 0, 0, ALU_ADD, MD_OP_MULL, 32'd0, 32'd0);
      want(0, SDivEn, 0, "fl_div_off"); want(0, SWbV, 0, "fl_wb_v");
      want(0, SBusy, 0, "fl_busy"); want(0, SImd0, 64'h1_2345_6789, "fl_imd0");
      want(0, SImd1, 64'h3_0000_0001, "fl_imd1"); cyc();
      wb_ready = 1'b1; cyc();

      // Asynchronous reset in the middle of a MUL
      op(1, 1, 0, ALU_ADD, MD_OP_MULL, 32'd3, 32'd4); cyc();
      op(0, 0, 0, ALU_ADD, MD_OP_MULL, 32'd0, 32'd0);
      imd_we = 2'b01; imd_d[0] = 34'h0_0000_00AA; want(0, SMulEn, 1, "rm_mul_en"); cyc();
      imd_we = 2'b00; rst_n = 1'b0;
      want(0, SMulEn, 0, "rm_mul_en0"); want(0, SFirst, 0, "rm_first0");
      want(0, SImd0, 0, "rm_imd0");     want(0, SBusy, 0, "rm_busy0");
      want(0, SAluA, 0, "rm_alu_a0"); cyc();
      rst_n = 1'b1; op(1, 0, 0, ALU_ADD, MD_OP_MULL, 32'd8, 32'd9); cyc();
      op(0, 0, 0, ALU_ADD, MD_OP_MULL, 32'd0, 32'd0); ex(1, 32'h3333);
      want(0, SFirst, 1, "rm_first"); want(0, SAluA, 8, "rm_alu_a"); cyc();
      ex(0, 32'h0); want(0, SWbV, 1, "rm_wb_v"); want(0, SWbD, 64'h3333, "rm_wb_res"); cyc();
      repeat (2) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
